// File: rtl/fc_load_sequencer.sv
// Streams flatten data, weight1, weight2 and a one-hot right-answer vector into the FC external write port.
// Optional AUTO_ENABLE_EN: raise fc_enable after a load that included the right-answer phase.
module fc_load_sequencer #(
    parameter int FRT_CELL = 14,
    parameter int MID_CELL = 10,
    parameter int BCK_CELL = 5,
    parameter int ONE_VAL  = 1536,
    parameter int SRC_AW   = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [3:0]        load_sel,
    input  logic [7:0]        answer_idx,
    output logic              src_rd_en,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [15:0]       src_data,
    output logic              ex_we,
    output logic [15:0]       ex_addr,
    output logic [15:0]       ex_value,
    output logic              weight1,
    output logic              weight2,
    output logic              right_answer,
    input  logic              fc_all_end,
    output logic              fc_enable,
    output logic              busy,
    output logic              load_done
);

    localparam int CW = $clog2(FRT_CELL * MID_CELL);
    localparam logic [CW-1:0] LAST_FLAT = CW'(FRT_CELL - 1);
    localparam logic [CW-1:0] LAST_W1   = CW'(FRT_CELL * MID_CELL - 1);
    localparam logic [CW-1:0] LAST_W2   = CW'(MID_CELL * BCK_CELL - 1);
    localparam logic [CW-1:0] LAST_ANS  = CW'(BCK_CELL - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, GAP, DONE} state_t;
    typedef enum logic [1:0] {PH_FLAT, PH_W1, PH_W2, PH_ANS} phase_t;

    typedef struct packed {
        logic        ans;
        logic [15:0] addr;
        logic [15:0] val;
    } wr_t;

    state_t      state, state_n;
    phase_t      phase, nxt_phase;
    logic        nxt_found;
    logic [3:0]  sel_q, scan_sel;
    logic [2:0]  scan_lo;
    logic [7:0]  idx_q;
    logic [CW-1:0] cnt, cnt_last;
    logic [1:0]  vld_pipe;
    wr_t         wr_q;
    logic [15:0] fc_base;
    logic [SRC_AW-1:0] src_base;
    logic        start_ok, flags_on;

    // Lowest selected phase at or after the scan start; IDLE scans the live mask.
    always_comb begin
        scan_sel  = (state == IDLE) ? load_sel : sel_q;
        scan_lo   = (state == IDLE) ? 3'd0 : ({1'b0, phase} + 3'd1);
        nxt_found = 1'b0;
        nxt_phase = PH_FLAT;
        for (int p = 3; p >= 0; p--) begin
            if (3'(p) >= scan_lo && scan_sel[p]) begin
                nxt_found = 1'b1;
                nxt_phase = phase_t'(2'(p));
            end
        end
    end

    always_comb begin
        cnt_last = LAST_FLAT;
        fc_base  = 16'd0;
        src_base = '0;
        case (phase)
            PH_FLAT: begin cnt_last = LAST_FLAT; fc_base = 16'd0;          src_base = '0; end
            PH_W1:   begin cnt_last = LAST_W1;   fc_base = 16'(FRT_CELL);  src_base = SRC_AW'(FRT_CELL); end
            PH_W2:   begin cnt_last = LAST_W2;   fc_base = 16'(MID_CELL);  src_base = SRC_AW'(FRT_CELL * (1 + MID_CELL)); end
            default: begin cnt_last = LAST_ANS;  fc_base = 16'(BCK_CELL);  src_base = '0; end
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_ok) state_n = nxt_found ? SETUP : DONE;
            SETUP:   state_n = STREAM;
            STREAM:  if (cnt == cnt_last) state_n = DRAIN;
            DRAIN:   state_n = GAP;
            GAP:     state_n = nxt_found ? SETUP : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= PH_FLAT;
            sel_q       <= '0;
            idx_q       <= '0;
            cnt         <= '0;
            vld_pipe[1] <= 1'b0;
            wr_q        <= '0;
        end else begin
            if (state == IDLE && start_ok) begin
                sel_q <= load_sel;
                idx_q <= answer_idx;
                phase <= nxt_phase;
                cnt   <= '0;
            end else if (state == GAP && nxt_found) begin
                phase <= nxt_phase;
            end else if (state == STREAM) begin
                cnt <= (cnt == cnt_last) ? '0 : cnt + 1'b1;
            end
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0]) begin
                wr_q.ans  <= (phase == PH_ANS);
                wr_q.addr <= fc_base + 16'(cnt);
                wr_q.val  <= (phase == PH_ANS && 16'(cnt) == 16'(idx_q)) ? 16'(ONE_VAL) : 16'd0;
            end else begin
                wr_q <= '0;
            end
        end
    end

    assign vld_pipe[0] = (state == STREAM);
    assign src_rd_en   = vld_pipe[0] && (phase != PH_ANS);
    assign src_addr    = src_rd_en ? (src_base + SRC_AW'(cnt)) : '0;

    // Source data arrives the cycle after the read, aligned with the registered write.
    assign ex_we    = vld_pipe[1];
    assign ex_addr  = wr_q.addr;
    assign ex_value = !vld_pipe[1] ? 16'd0 : (wr_q.ans ? wr_q.val : src_data);

    assign flags_on     = (state == SETUP) || (state == STREAM) || (state == DRAIN) || (state == GAP);
    assign weight1      = flags_on && (phase == PH_W1);
    assign weight2      = flags_on && (phase == PH_W2);
    assign right_answer = flags_on && (phase == PH_ANS);
    assign busy         = (state != IDLE);
    assign load_done    = (state == DONE);

`ifdef AUTO_ENABLE_EN
    logic en_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                     en_q <= 1'b0;
        else if (state == GAP && state_n == DONE && sel_q[3]) en_q <= 1'b1;
        else if (en_q && fc_all_end)                      en_q <= 1'b0;
    end
    assign fc_enable = en_q;
    assign start_ok  = load_start && !en_q;
`else
    logic unused_fc_all_end;
    assign unused_fc_all_end = fc_all_end;
    assign fc_enable = 1'b0;
    assign start_ok  = load_start;
`endif

endmodule

// File: tb/tb_fc_load_sequencer.sv
// Scoreboard bench for fc_load_sequencer: expected FC writes queued at start, popped as ex_we fires.
module tb_fc_load_sequencer;

    localparam int FRT = 14, MID = 10, BCK = 5;

    logic        clk = 0, reset_n = 0;
    logic        load_start = 0;
    logic [3:0]  load_sel = 0;
    logic [7:0]  answer_idx = 0;
    logic        src_rd_en;
    logic [15:0] src_addr;
    logic [15:0] src_data = 0;
    logic        ex_we, weight1, weight2, right_answer;
    logic [15:0] ex_addr, ex_value;
    logic        fc_all_end = 0, fc_enable, busy, load_done;

    fc_load_sequencer dut (
        .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_sel(load_sel),
        .answer_idx(answer_idx), .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .ex_we(ex_we), .ex_addr(ex_addr), .ex_value(ex_value), .weight1(weight1), .weight2(weight2),
        .right_answer(right_answer), .fc_all_end(fc_all_end), .fc_enable(fc_enable),
        .busy(busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) if (src_rd_en) src_data <= mem[src_addr[7:0]];

    logic [34:0] q[$];
    int errors = 0, checks = 0;
    logic no_rd = 0;

    // Write monitor: every FC write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (no_rd && src_rd_en) begin
                checks++; errors++;
                $display("FAIL src_rd_unexpected addr=%0d", src_addr);
            end
            if (ex_we) begin
                logic [34:0] got, e;
                got = {ex_addr, ex_value, right_answer, weight2, weight1};
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got addr=%0d val=%0d flags=%b", ex_addr, ex_value, got[2:0]);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL write got addr=%0d val=%0d flags=%b need addr=%0d val=%0d flags=%b",
                                 got[34:19], got[18:3], got[2:0], e[34:19], e[18:3], e[2:0]);
                    end
                end
            end
        end
    end

    task automatic init_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        for (int i = 0; i < FRT; i++)       mem[i]                 = 16'(10 + 10 * i);
        for (int i = 0; i < FRT * MID; i++) mem[FRT + i]           = 16'(-250 + 3 * i);
        for (int i = 0; i < MID * BCK; i++) mem[FRT * (1 + MID) + i] = 16'(-250 + 10 * i);
    endtask

    task automatic push_exp(input logic [3:0] sel, input logic [7:0] idx);
        if (sel[0]) for (int i = 0; i < FRT; i++)       q.push_back({16'(i), mem[i], 3'b000});
        if (sel[1]) for (int i = 0; i < FRT * MID; i++) q.push_back({16'(FRT + i), mem[FRT + i], 3'b001});
        if (sel[2]) for (int i = 0; i < MID * BCK; i++) q.push_back({16'(MID + i), mem[FRT * (1 + MID) + i], 3'b010});
        if (sel[3]) for (int i = 0; i < BCK; i++)
            q.push_back({16'(BCK + i), (8'(i) == idx) ? 16'd1536 : 16'd0, 3'b100});
    endtask

    task automatic run_seq(input logic [3:0] sel, input logic [7:0] idx, input int poke, input string name);
        int n, exp_n;
        exp_n = 1;
        if (sel[0]) exp_n += FRT + 3;
        if (sel[1]) exp_n += FRT * MID + 3;
        if (sel[2]) exp_n += MID * BCK + 3;
        if (sel[3]) exp_n += BCK + 3;
        push_exp(sel, idx);
        no_rd = (sel[2:0] == 3'b000);
        @(negedge clk); load_sel = sel; answer_idx = idx; load_start = 1;
        @(negedge clk); load_start = 0; n = 1;
        while (!load_done && n < 400) begin
            @(negedge clk); n++;
            load_start = (n == poke);
            if (n == poke) begin load_sel = 4'b1000; answer_idx = 8'd2; end
        end
        load_start = 0;
        checks++;
        if (!load_done || n != exp_n) begin
            errors++; $display("FAIL %s done_cycle got=%0d need=%0d", name, n, exp_n);
        end
        checks++;
`ifdef AUTO_ENABLE_EN
        if (fc_enable !== sel[3]) begin
            errors++; $display("FAIL %s fc_enable_at_done got=%b need=%b", name, fc_enable, sel[3]);
        end
`else
        if (fc_enable !== 1'b0) begin
            errors++; $display("FAIL %s fc_enable got=%b need=0", name, fc_enable);
        end
`endif
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || load_done !== 1'b0) begin
            errors++; $display("FAIL %s after_done busy=%b done=%b need 0 0", name, busy, load_done);
        end
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL %s missing_writes got=%0d need=0", name, q.size());
        end
        q.delete();
        no_rd = 0;
`ifdef AUTO_ENABLE_EN
        if (sel[3]) begin
            repeat (3) @(negedge clk);
            checks++;
            if (fc_enable !== 1'b1) begin errors++; $display("FAIL %s fc_enable_hold got=%b need=1", name, fc_enable); end
            fc_all_end = 1;
            @(negedge clk); fc_all_end = 0;
            checks++;
            if (fc_enable !== 1'b0) begin errors++; $display("FAIL %s fc_enable_fall got=%b need=0", name, fc_enable); end
        end
`endif
    endtask

    task automatic check_all_zero(input string name);
        logic [70:0] v;
        v = {src_rd_en, src_addr, ex_we, ex_addr, ex_value, weight1, weight2, right_answer,
             fc_enable, busy, load_done};
        checks++;
        if (v !== '0) begin errors++; $display("FAIL %s outputs got=%h need=0", name, v); end
    endtask

    task automatic test_reset();
        src_data = 16'hBEEF;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1;
        @(negedge clk);
        check_all_zero("idle");
    endtask

    task automatic test_flatten();   run_seq(4'b0001, 8'd0, 0, "flatten"); endtask
    task automatic test_full();      run_seq(4'b1111, 8'd3, 0, "full");    endtask

    task automatic test_answer();
        run_seq(4'b1000, 8'd1, 0, "answer_idx1");
        run_seq(4'b1000, 8'd7, 0, "answer_idx7");
    endtask

    task automatic test_busy_ignore();
        run_seq(4'b0001, 8'd0, 5, "busy_ignore");
        run_seq(4'b0000, 8'd0, 0, "sel_zero");
    endtask

    task automatic test_reset_mid();
        int n;
        push_exp(4'b1111, 8'd0);
        @(negedge clk); load_sel = 4'b1111; answer_idx = 0; load_start = 1;
        @(negedge clk); load_start = 0; n = 0;
        while (!(ex_we && weight1 && ex_addr == 16'(FRT + 50)) && n < 300) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 300) begin errors++; $display("FAIL reset_mid reach_w1_50 got=timeout need=hit"); end
        #1 reset_n = 0;
        #1 check_all_zero("reset_mid_async");
        q.delete();
        @(negedge clk); reset_n = 1;
        run_seq(4'b0001, 8'd0, 0, "replay_flatten");
    endtask

    initial begin
        init_mem();
        test_reset();
        test_flatten();
        test_full();
        test_answer();
        test_busy_ignore();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
